mem_wb_stage: RTL



---
 rtl/mem_wb_stage.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory stage plus MEM/WB pipeline register.
//
// Loads and stores go to an internal word-addressed data memory. Each access takes
// MEM_LAT cycles. While an access is in progress, freeze stalls the upstream stages.
// The MEM/WB register drives the register-file write port, which captures on the
// falling edge.
//
// Optional build macro: MEM_FWD_EN adds combinational forwarding outputs.
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   MEM_R_EN, MEM_W_EN   load / store request (mutually exclusive)
//   WB_EN_in, Dest_in    register write enable and destination index
//   ALU_Res              ALU result, also the byte address for memory ops
//   Val_Rm               store data
//   freeze               combinational stall request to upstream stages
//   WB_WB_EN/Dest/Value  registered write-back to the register file
//   Mem_Addr_Err         one-cycle pulse on completion of an out-of-range access
//   MEM_Fwd_*            (MEM_FWD_EN only) combinational forwarding taps
module mem_wb_stage #(
    parameter int unsigned DEPTH     = 64,
    parameter int unsigned MEM_LAT   = 3,
    parameter logic [31:0] ADDR_BASE = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    input  logic        WB_EN_in,
    input  logic [3:0]  Dest_in,
    input  logic [31:0] ALU_Res,
    input  logic [31:0] Val_Rm,
    output logic        freeze,
    output logic        WB_WB_EN,
    output logic [3:0]  WB_Dest,
    output logic [31:0] WB_Value,
    output logic        Mem_Addr_Err
`ifdef MEM_FWD_EN
    ,
    output logic        MEM_Fwd_EN,
    output logic [3:0]  MEM_Fwd_Dest,
    output logic [31:0] MEM_Fwd_Val
`endif
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = (MEM_LAT > 1) ? $clog2(MEM_LAT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LAT - 1);
    localparam logic [31:0] MEM_BYTES = 32'(DEPTH * 4);

    typedef enum logic {StIdle, StWait} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            req;
    logic            done;
    logic [31:0]     off;
    logic            in_range;
    logic [AW-1:0]   idx;
    logic [31:0]     load_data;
    logic [31:0]     stage_val;

    logic [31:0] mem [DEPTH];

    // Address decode; the two low address bits are ignored.
    assign off      = ALU_Res - ADDR_BASE;
    assign in_range = off < MEM_BYTES;
    assign idx      = off[AW+1:2];
    assign req      = MEM_R_EN | MEM_W_EN;

    assign load_data = in_range ? mem[idx] : 32'd0;
    assign stage_val = MEM_R_EN ? load_data : ALU_Res;

    // Access-latency FSM. cnt counts completed wait cycles of the current access.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    if (MEM_LAT == 1) begin
                        done = 1'b1;
                    end else begin
                        state_d = StWait;
                        cnt_d   = CW'(1);
                    end
                end
            end
            StWait: begin
                if (cnt_q == CNT_LAST) begin
                    done    = req;
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    assign freeze = req & ~done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Memory contents are deliberately not reset; reset only suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst && done && MEM_W_EN && in_range) begin
            mem[idx] <= Val_Rm;
        end
    end

    // MEM/WB register: a stall injects a bubble and holds dest/value.
    always_ff @(posedge clk) begin
        if (rst) begin
            WB_WB_EN     <= 1'b0;
            WB_Dest      <= 4'd0;
            WB_Value     <= 32'd0;
            Mem_Addr_Err <= 1'b0;
        end else begin
            Mem_Addr_Err <= done & ~in_range;
            if (freeze) begin
                WB_WB_EN <= 1'b0;
            end else begin
                WB_WB_EN <= WB_EN_in;
                WB_Dest  <= Dest_in;
                WB_Value <= stage_val;
            end
        end
    end

`ifdef MEM_FWD_EN
    assign MEM_Fwd_EN   = WB_EN_in & ~freeze;
    assign MEM_Fwd_Dest = Dest_in;
    assign MEM_Fwd_Val  = stage_val;
`endif

endmodule
